// File: rtl/dt_collector.sv
// dt_collector: captures {addr,data} words from a producer that cannot be
// stalled, buffers them in a small show-ahead FIFO, and keeps a sticky
// overflow flag, a saturating accepted-word count and a running XOR checksum.
module dt_collector #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    dft_tm_i,
    input  logic                    en_i,
    input  logic                    in_valid_i,
    input  logic [ADDR_WIDTH-1:0]   in_addr_i,
    input  logic [DATA_WIDTH-1:0]   in_dt_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [ADDR_WIDTH-1:0]   out_addr_o,
    output logic [DATA_WIDTH-1:0]   out_dt_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    ovf_o,
    output logic [15:0]             acc_cnt_o,
    output logic [DATA_WIDTH-1:0]   chk_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
    logic [DATA_WIDTH-1:0] mem_dt   [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level;

    logic push_req;
    logic pop;
    logic push_ok;
    logic drop;

    // Test mode has no functional effect; it is only routed to keep the port.
    logic unused_dft;
    assign unused_dft = dft_tm_i;

    assign level_o     = level;
    assign full_o      = (level == LW'(DEPTH));
    assign empty_o     = (level == '0);
    assign out_valid_o = !empty_o;
    assign out_addr_o  = mem_addr[rd_ptr];
    assign out_dt_o    = mem_dt[rd_ptr];

    assign push_req = en_i & in_valid_i;
    assign pop      = out_valid_o & out_ready_i;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign push_ok  = push_req & (!full_o | pop);
    assign drop     = push_req & full_o & !pop;

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok) begin
            mem_addr[wr_ptr] <= in_addr_i;
            mem_dt[wr_ptr]   <= in_dt_i;
        end
    end

    // Pointers, level, overflow flag, counter and checksum.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            ovf_o     <= 1'b0;
            acc_cnt_o <= '0;
            chk_o     <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
                chk_o  <= chk_o ^ in_dt_i;
                if (acc_cnt_o != 16'hFFFF) begin
                    acc_cnt_o <= acc_cnt_o + 16'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push_ok) begin
                level <= level - LW'(1);
            end
            if (drop) begin
                ovf_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dt_collector.sv
// Scoreboard bench for dt_collector: the driver predicts accepted words into a
// queue; a negedge monitor compares the presented head against the queue front.
module tb_dt_collector;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          dft_tm_i;
    logic          en_i;
    logic          in_valid_i;
    logic [AW-1:0] in_addr_i;
    logic [DW-1:0] in_dt_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [AW-1:0] out_addr_o;
    logic [DW-1:0] out_dt_o;
    logic [2:0]    level_o;
    logic          full_o;
    logic          empty_o;
    logic          ovf_o;
    logic [15:0]   acc_cnt_o;
    logic [DW-1:0] chk_o;

    always #5 clk_i = ~clk_i;

    dt_collector #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .dft_tm_i    (dft_tm_i),
        .en_i        (en_i),
        .in_valid_i  (in_valid_i),
        .in_addr_i   (in_addr_i),
        .in_dt_i     (in_dt_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_addr_o  (out_addr_o),
        .out_dt_o    (out_dt_o),
        .level_o     (level_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .ovf_o       (ovf_o),
        .acc_cnt_o   (acc_cnt_o),
        .chk_o       (chk_o)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of accepted words plus the derived status.
    logic [AW+DW-1:0] exp_q [$];
    int               m_level;
    bit               m_ovf;
    int               m_acc;
    logic [DW-1:0]    m_chk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        chk("level", int'(level_o), m_level);
        chk("full", int'(full_o), int'(m_level == DEPTH));
        chk("empty", int'(empty_o), int'(m_level == 0));
        chk("out_valid", int'(out_valid_o), int'(m_level != 0));
        chk("ovf", int'(ovf_o), int'(m_ovf));
        chk("acc_cnt", int'(acc_cnt_o), m_acc);
        chk("chk", int'(chk_o), int'(m_chk));
    endtask

    // Apply one cycle of stimulus, predict its effect, then check after the edge.
    task automatic drive(input bit r, input bit e, input bit v,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input bit rdy);
        bit do_pop;
        bit do_push;
        rst_i       = r;
        en_i        = e;
        in_valid_i  = v;
        in_addr_i   = a;
        in_dt_i     = d;
        out_ready_i = rdy;
        dft_tm_i    = 1'b0;
        if (r) begin
            m_level = 0;
            m_ovf   = 1'b0;
            m_acc   = 0;
            m_chk   = '0;
            exp_q.delete();
        end else begin
            do_pop  = rdy && (m_level > 0);
            do_push = e && v;
            if (do_push && (m_level < DEPTH || do_pop)) begin
                exp_q.push_back({a, d});
                m_acc = (m_acc == 65535) ? m_acc : m_acc + 1;
                m_chk = m_chk ^ d;
                m_level++;
            end else if (do_push) begin
                m_ovf = 1'b1;
            end
            if (do_pop) m_level--;
        end
        @(posedge clk_i);
        #1;
        check_status();
    endtask

    // Monitor: the presented head must match the oldest predicted word.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && out_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL head: got 0x%0h expected no word at %0t", {out_addr_o, out_dt_o}, $time);
            end else begin
                chk("head", int'({out_addr_o, out_dt_o}), int'(exp_q[0]));
                if (out_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset for two cycles.
        drive(1, 0, 0, 8'h00, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 8'h00, 0);
        chk("rst_empty", int'(empty_o), 1);
        chk("rst_acc", int'(acc_cnt_o), 0);

        // Three words held, then drained in order.
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 8'(i), 8'(8'hA0 + i), 0);
        chk("level3", int'(level_o), 3);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 8'h00, 8'h00, 1);
        chk("drain_empty", int'(empty_o), 1);
        chk("chk_a3", int'(chk_o), 8'hA3);
        chk("acc3", int'(acc_cnt_o), 3);

        // Overflow: fifth word dropped, flag sticky after draining.
        drive(1, 0, 0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 1, 8'(8'h10 + i), 8'(8'hB0 + i), 0);
        chk("full4", int'(full_o), 1);
        drive(0, 1, 1, 8'h14, 8'hB4, 0);
        chk("ovf_set", int'(ovf_o), 1);
        chk("acc4", int'(acc_cnt_o), 4);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 8'h00, 8'h00, 1);
        chk("ovf_sticky", int'(ovf_o), 1);

        // Full with simultaneous push and pop.
        drive(1, 0, 0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 1, 8'(8'h20 + i), 8'(8'hC0 + i), 0);
        drive(0, 1, 1, 8'h24, 8'h55, 1);
        chk("full_pp_level", int'(level_o), 4);
        chk("full_pp_ovf", int'(ovf_o), 0);
        for (int i = 0; i < 2; i++) drive(0, 0, 0, 8'h00, 8'h00, 1);

        // Capture disabled while the stored words drain.
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 8'(8'h30 + i), 8'(8'hD0 + i), 1);
        chk("en0_empty", int'(empty_o), 1);
        chk("en0_acc", int'(acc_cnt_o), 5);

        // Reset mid-operation with push and pop active.
        drive(1, 0, 0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 1, 8'(8'h40 + i), 8'(8'hE0 + i), 0);
        for (int i = 0; i < 2; i++) drive(0, 0, 0, 8'h00, 8'h00, 1);
        chk("pre_rst_level", int'(level_o), 2);
        drive(1, 1, 1, 8'h4F, 8'hEF, 1);
        chk("mid_rst_level", int'(level_o), 0);
        chk("mid_rst_ovf", int'(ovf_o), 0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
